// File: rtl/gate_truth_sequencer_pkg.sv
// Shared types and reference truth tables for the 2-input gate check sequencers.
package gate_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef logic [1:0] vec_t;

  // Bit index is {A,B}, so bit 0 is the response to A=0,B=0.
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic tt_lookup(input logic [3:0] tt, input vec_t v);
    return tt[v];
  endfunction

endpackage

// File: rtl/gate_truth_sequencer_if.sv
// Stimulus/response and verdict bundle between a gate sequencer and its gate/host.
interface gate_truth_sequencer_if #(parameter int ERR_W = 4);
  logic             start;
  logic             A;
  logic             B;
  logic             Out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       first_err_vec;
  logic             first_err_valid;

  modport master (
    input  start, Out,
    output A, B, busy, done, pass, err_count, first_err_vec, first_err_valid
  );

  modport slave (
    output start, Out,
    input  A, B, busy, done, pass, err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/gate_truth_sequencer_hold_timer.sv
// Down-counter from HOLD_CYCLES-1; expire_o marks the last cycle of each hold window
// and the counter reloads itself on that cycle so windows run back to back.
module hold_timer #(
  parameter int HOLD_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i || expire_o) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/gate_truth_sequencer.sv
// Sweeps {A,B} through 00..11 for PASSES passes, holding each vector HOLD_CYCLES cycles,
// and checks the gate response against TRUTH at the end of every hold window.
module gate_truth_sequencer
  import gate_tb_pkg::*;
#(
  parameter int         HOLD_CYCLES = 5,
  parameter logic [3:0] TRUTH       = TT_NOR,
  parameter int         PASSES      = 2,
  parameter int         ERR_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_truth_sequencer_if.master bus
);
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  state_e           state_q, state_d;
  vec_t             vec_q, vec_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pass_q, pass_d;
  vec_t             fev_q, fev_d;
  logic             fv_q, fv_d;

  logic start_acc;
  logic expire;
  logic mismatch;
  logic last_vec;

  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign mismatch  = expire && (bus.Out != tt_lookup(TRUTH, vec_q));
  assign last_vec  = expire && (vec_q == 2'b11) && (pcnt_q == PW'(PASSES - 1));

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (start_acc),
    .en_i     (state_q == ST_DRIVE),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start) state_d = ST_DRIVE;
      ST_DRIVE: if (last_vec)  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy            = (state_q == ST_DRIVE);
    bus.done            = (state_q == ST_DONE);
    bus.A               = vec_q[1];
    bus.B               = vec_q[0];
    bus.pass            = pass_q;
    bus.err_count       = err_q;
    bus.first_err_vec   = fev_q;
    bus.first_err_valid = fv_q;
  end

  // The vector wraps to 00 after the final sample, so A/B read 0 in DONE and IDLE.
  always_comb begin
    vec_d  = vec_q;
    pcnt_d = pcnt_q;
    err_d  = err_q;
    pass_d = pass_q;
    fev_d  = fev_q;
    fv_d   = fv_q;
    if (start_acc) begin
      vec_d  = '0;
      pcnt_d = '0;
      err_d  = '0;
      pass_d = 1'b0;
      fv_d   = 1'b0;
    end else if (expire) begin
      vec_d = vec_q + 2'd1;
      if (vec_q == 2'b11) begin
        pcnt_d = pcnt_q + PW'(1);
      end
      if (mismatch) begin
        if (err_q != '1) begin
          err_d = err_q + ERR_W'(1);
        end
        if (!fv_q) begin
          fv_d  = 1'b1;
          fev_d = vec_q;
        end
      end
      // Saturation only ever holds a nonzero count, so a zero test stays exact.
      if (last_vec) begin
        pcnt_d = '0;
        pass_d = (err_d == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      pcnt_q <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      fev_q  <= '0;
      fv_q   <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      pcnt_q <= pcnt_d;
      err_q  <= err_d;
      pass_q <= pass_d;
      fev_q  <= fev_d;
      fv_q   <= fv_d;
    end
  end
endmodule

// File: tb/tb_gate_truth_sequencer.sv
// Two sequencer instances (NOR/5-cycle/2-pass and XOR/1-cycle/1-pass/2-bit counter)
// driven with random gates; a negedge monitor scores each run against a reference model.
module tb_gate_truth_sequencer;
  import gate_tb_pkg::*;

  localparam int H0 = 5, P0 = 2, W0 = 4;
  localparam int H1 = 1, P1 = 1, W1 = 2;
  localparam int LEN0 = P0 * 4 * H0;
  localparam int LEN1 = P1 * 4 * H1;

  typedef struct {
    int         err;
    logic       pass;
    logic       fv;
    logic [1:0] fev;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  int         gsel0, gsel1;
  logic [3:0] rtt0, rtt1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t eq0[$];
  exp_t eq1[$];
  int   bcnt[2]      = '{0, 0};
  logic rst_pend[2]  = '{1'b0, 1'b0};
  logic last_pass[2] = '{1'b0, 1'b0};
  int   last_err[2]  = '{0, 0};

  gate_truth_sequencer_if #(.ERR_W(W0)) if0 ();
  gate_truth_sequencer_if #(.ERR_W(W1)) if1 ();

  gate_truth_sequencer #(.HOLD_CYCLES(H0), .TRUTH(TT_NOR), .PASSES(P0), .ERR_W(W0)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (if0)
  );

  gate_truth_sequencer #(.HOLD_CYCLES(H1), .TRUTH(TT_XOR), .PASSES(P1), .ERR_W(W1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (if1)
  );

  // Gate under test: 0 NOR, 1 OR, 2 stuck-at-0, 3 XOR, 4 XNOR, 5 AND, 6 NAND, else random table.
  function automatic logic gate_fn(input int sel, input logic a, input logic b, input logic [3:0] rt);
    case (sel)
      0:       return ~(a | b);
      1:       return a | b;
      2:       return 1'b0;
      3:       return a ^ b;
      4:       return ~(a ^ b);
      5:       return a & b;
      6:       return ~(a & b);
      default: return rt[{a, b}];
    endcase
  endfunction

  always_comb if0.Out = gate_fn(gsel0, if0.A, if0.B, rtt0);
  always_comb if1.Out = gate_fn(gsel1, if1.A, if1.B, rtt1);

  function automatic exp_t model(input int i, input int sel, input logic [3:0] rt);
    exp_t e;
    int   n      = 0;
    int   passes = (i == 0) ? P0 : P1;
    int   maxe   = (i == 0) ? (1 << W0) - 1 : (1 << W1) - 1;
    logic a, b, want;
    e.fv  = 1'b0;
    e.fev = 2'b00;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        a    = v[1];
        b    = v[0];
        want = (i == 0) ? ~(a | b) : (a ^ b);
        if (gate_fn(sel, a, b, rt) != want) begin
          n++;
          if (!e.fv) begin
            e.fv  = 1'b1;
            e.fev = 2'(v);
          end
        end
      end
    end
    e.err  = (n > maxe) ? maxe : n;
    e.pass = (n == 0);
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon(input int i);
    int    busy_v, done_v, ab, err, ps, fv, fev, rs, len, h;
    exp_t  e;
    logic  have;
    string p;
    p = (i == 0) ? "i0" : "i1";
    if (i == 0) begin
      busy_v = int'(if0.busy); done_v = int'(if0.done); ab = int'({if0.A, if0.B});
      err = int'(if0.err_count); ps = int'(if0.pass); fv = int'(if0.first_err_valid);
      fev = int'(if0.first_err_vec); rs = int'(rst0); len = LEN0; h = H0;
    end else begin
      busy_v = int'(if1.busy); done_v = int'(if1.done); ab = int'({if1.A, if1.B});
      err = int'(if1.err_count); ps = int'(if1.pass); fv = int'(if1.first_err_valid);
      fev = int'(if1.first_err_vec); rs = int'(rst1); len = LEN1; h = H1;
    end
    if (rst_pend[i]) begin
      chk({p, "_rst_busy"}, busy_v, 0);
      chk({p, "_rst_done"}, done_v, 0);
      chk({p, "_rst_ab"}, ab, 0);
      chk({p, "_rst_err"}, err, 0);
      chk({p, "_rst_pass"}, ps, 0);
      chk({p, "_rst_fv"}, fv, 0);
      chk({p, "_rst_fev"}, fev, 0);
      bcnt[i]      = 0;
      last_pass[i] = 1'b0;
      last_err[i]  = 0;
    end else if (done_v != 0) begin
      have = (i == 0) ? (eq0.size() > 0) : (eq1.size() > 0);
      if (!have) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_done: done=1, expected no run pending (t=%0t)", p, $time);
      end else begin
        if (i == 0) e = eq0.pop_front();
        else        e = eq1.pop_front();
        chk({p, "_run_len"}, bcnt[i], len);
        chk({p, "_err_count"}, err, e.err);
        chk({p, "_pass"}, ps, int'(e.pass));
        chk({p, "_first_err_valid"}, fv, int'(e.fv));
        if (e.fv) chk({p, "_first_err_vec"}, fev, int'(e.fev));
        last_pass[i] = e.pass;
        last_err[i]  = e.err;
      end
      chk({p, "_done_ab"}, ab, 0);
      bcnt[i] = 0;
    end else if (busy_v != 0) begin
      chk({p, "_vec"}, ab, (bcnt[i] / h) % 4);
      chk({p, "_busy_pass"}, ps, 0);
      bcnt[i]++;
    end else begin
      chk({p, "_idle_ab"}, ab, 0);
      chk({p, "_idle_pass"}, ps, int'(last_pass[i]));
      chk({p, "_idle_err"}, err, last_err[i]);
    end
    rst_pend[i] = (rs != 0);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic drive(input int i, input logic st, input logic r);
    if (i == 0) begin
      if0.start = st;
      rst0      = r;
    end else begin
      if1.start = st;
      rst1      = r;
    end
  endtask

  function automatic int get_done(input int i);
    return (i == 0) ? int'(if0.done) : int'(if1.done);
  endfunction

  // mode: 0 plain run, 1 extra start mid-run, 2 reset mid-run, 3 start together with reset
  task automatic do_run(input int i, input int sel, input int mode, input int rj);
    int         len;
    int         j;
    int         k;
    exp_t       e;
    logic [3:0] rt;
    len = (i == 0) ? LEN0 : LEN1;
    rt  = 4'($urandom);
    if (i == 0) begin gsel0 = sel; rtt0 = rt; end
    else        begin gsel1 = sel; rtt1 = rt; end
    @(posedge clk); #1;
    if (mode == 3) begin
      drive(i, 1'b1, 1'b1);
      @(posedge clk); #1;
      drive(i, 1'b0, 1'b0);
      @(posedge clk); #1;
    end else begin
      e = model(i, sel, rt);
      if (i == 0) eq0.push_back(e);
      else        eq1.push_back(e);
      drive(i, 1'b1, 1'b0);
      @(posedge clk); #1;
      drive(i, 1'b0, 1'b0);
      if (mode == 1) begin
        j = $urandom_range(1, len - 2);
        repeat (j) begin @(posedge clk); #1; end
        drive(i, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(i, 1'b0, 1'b0);
      end
      if (mode == 2) begin
        j = (rj >= 0) ? rj : $urandom_range(0, len - 2);
        repeat (j) begin @(posedge clk); #1; end
        drive(i, 1'b0, 1'b1);
        if (i == 0) void'(eq0.pop_back());
        else        void'(eq1.pop_back());
        @(posedge clk); #1;
        drive(i, 1'b0, 1'b0);
        @(posedge clk); #1;
      end else begin
        k = 0;
        while (get_done(i) == 0 && k < len + 8) begin
          @(posedge clk); #1;
          k++;
        end
        chk((i == 0) ? "i0_done_seen" : "i1_done_seen", get_done(i), 1);
        @(posedge clk); #1;
      end
    end
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m;
    rst0 = 1'b1; rst1 = 1'b1;
    if0.start = 1'b0; if1.start = 1'b0;
    gsel0 = 0; gsel1 = 3; rtt0 = 4'h0; rtt1 = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;
    fork
      begin
        do_run(0, 0, 0, -1);   // good NOR
        do_run(0, 1, 0, -1);   // OR attached: 8 mismatches
        do_run(0, 2, 0, -1);   // stuck-at-0: 2 mismatches
        do_run(0, 0, 2, 11);   // reset during vector 10 of pass 0
        do_run(0, 0, 1, -1);   // start ignored mid-run
        do_run(0, 0, 3, -1);   // reset wins over start
        do_run(0, 0, 0, -1);
        repeat (25) begin
          m = $urandom_range(0, 9);
          do_run(0, $urandom_range(0, 7), (m < 6) ? 0 : m - 6, -1);
        end
      end
      begin
        do_run(1, 3, 0, -1);   // good XOR at minimum hold
        do_run(1, 4, 0, -1);   // XNOR: 4 mismatches saturate at 3
        repeat (60) begin
          m = $urandom_range(0, 9);
          do_run(1, $urandom_range(0, 7), (m < 6) ? 0 : m - 6, -1);
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("i0_queue_drained", eq0.size(), 0);
    chk("i1_queue_drained", eq1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
